mc6809_intvec_ctrl: RTL and testbench
=====================================

Name: mc6809_intvec_ctrl

Overview:
- Parametrised prioritised interrupt-vector controller for the 6809 superset core.
- Collects up to NCHAN peripheral requests, applies per-channel mask and edge/level mode, and drives the core's nIRQ.
- Supplies a per-channel Intvector that is frozen for the duration of the IRQ vector fetch.
- Generalises the single fixed Intvector input to N channels with programmable behaviour.

Parameters:
NCHAN, 8, number of request channels (1..8); channel 0 has highest priority.
VEC_BASE, 16'hFF00, vector address for channel 0; channel i vector = VEC_BASE + 2*i.
DEFAULT_VEC, 16'hFFF8, vector driven when no enabled request is pending (spurious or idle).

Ports:
CLK  in  1  system clock, all state on rising edge.
RESET  in  1  synchronous reset, active-high.
REQ  in  NCHAN  peripheral requests, active-high, synchronous to CLK.
ADDR  in  16  CPU address bus.
BS  in  1  CPU bus status.
BA  in  1  CPU bus available.
WE  in  1  register write strobe; chip select is decoded externally.
REG_SEL  in  2  register select.
DIN  in  8  write data; bits above NCHAN-1 are ignored.
DOUT  out  8  read data; combinational mux on REG_SEL.
nIRQ  out  1  interrupt request to the core, active-low, registered.
Intvector  out  16  vector address to the core, registered.

Behaviour:
- Reset (RESET=1 at a CLK edge):
  - MASK=0, MODE=0, PEND=0, REQ_Q=0, state=IDLE.
  - nIRQ=1, Intvector=DEFAULT_VEC, DOUT=0x00 for all REG_SEL values.
  - Reset mid-ACK returns to IDLE with nothing preserved.
- Registers (writes take effect on the edge where WE=1):
  - 0 MASK rw: 1 = channel enabled.
  - 1 MODE rw: 1 = edge, 0 = level.
  - 2 PEND: read returns pending bits; write-1-to-clear applies to edge-mode bits only.
  - 3 STATUS ro: {state==ACK, 4'b0, ACT[2:0]}; writes ignored.
  - Unused high bits read 0.
- Pending logic, per channel i, each cycle:
  - REQ_Q <= REQ.
  - Level mode: PEND[i] <= REQ[i].
  - Edge mode: PEND[i] sets on REQ[i] & ~REQ_Q[i], clears on W1C or on ack completion.
  - If a set and a clear occur in the same cycle, set wins.
  - A MODE change to edge keeps the current PEND value.
- Output timing:
  - ELIG = PEND & MASK.
  - nIRQ <= ~|ELIG, giving 1 cycle from PEND to nIRQ.
  - Total latency for an edge: REQ rising to nIRQ low is 2 cycles.
- Winner selection: WIN = lowest index set in ELIG.
- Vector-fetch detect: VF = BS & ~BA & (ADDR[15:1]==15'h7FFC), i.e. 0xFFF8 or 0xFFF9.
- State machine:
  - IDLE:
    - Intvector <= (ELIG != 0) ? VEC_BASE + 2*WIN : DEFAULT_VEC every cycle.
    - On VF: ACT <= WIN and SPUR <= (ELIG == 0); Intvector holds its current value; go to ACK.
  - ACK:
    - Intvector is frozen.
    - MASK/MODE writes and new requests do not alter Intvector or ACT.
    - On ~VF: if ~SPUR and MODE[ACT], clear PEND[ACT] (set-wins rule applies); go to IDLE.
- Spurious fetch (no eligible request): DEFAULT_VEC is held and no PEND bit is cleared.
- Level-mode channels are never cleared by ack; the peripheral must drop REQ.
- Widths: vector arithmetic is 16-bit modulo 2^16; ACT is 3 bits, zero-extended.

Test Plan:
- Edge capture: MASK=0x01, MODE=0x01, pulse REQ[0] for 1 cycle → nIRQ low 2 cycles later, PEND=0x01, Intvector=0xFF00; after VF on 0xFFF8/0xFFF9 then release → PEND=0x00, nIRQ returns to 1 one cycle later.
- Priority: MASK=0xFF, MODE=0xFF, edges on REQ[5] and REQ[2] in the same cycle → Intvector=0xFF04; after ack → Intvector=0xFF0A, PEND=0x20.
- Freeze: during ACK of channel 3 (Intvector=0xFF06), assert REQ[1] edge and write MASK=0x00 → Intvector stays 0xFF06 until VF ends; PEND[1]=1 afterwards.
- Level mode: MODE=0, MASK=0x04, hold REQ[2]=1 through a full ack → PEND[2] stays 1 and nIRQ stays 0; drop REQ[2] → nIRQ=1 two cycles later.
- Spurious and W1C: VF with ELIG=0 → Intvector=0xFFF8, STATUS[7]=1 during the fetch, no PEND change. Write PEND=0x10 on the same cycle as a REQ[4] edge → PEND[4] stays 1.
- Reset mid-ACK: assert RESET during VF → next cycle nIRQ=1, Intvector=0xFFF8, MASK/MODE/PEND=0, STATUS=0x00.

Source files
------------

// File: rtl/mc6809_intvec_ctrl.sv
// Prioritised interrupt-vector controller for the 6809 superset core.
// Masked edge/level request channels drive nIRQ; the winner's vector is frozen across the IRQ fetch.
module mc6809_intvec_ctrl #(
  parameter int unsigned NCHAN       = 8,
  parameter logic [15:0] VEC_BASE    = 16'hFF00,
  parameter logic [15:0] DEFAULT_VEC = 16'hFFF8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [NCHAN-1:0] REQ,
  input  logic [15:0]      ADDR,
  input  logic             BS,
  input  logic             BA,
  input  logic             WE,
  input  logic [1:0]       REG_SEL,
  input  logic [7:0]       DIN,
  output logic [7:0]       DOUT,
  output logic             nIRQ,
  output logic [15:0]      Intvector
);

  typedef enum logic {IDLE, ACK} state_t;

  state_t           state, state_d;
  logic [NCHAN-1:0] mask, mode, pend, req_q;
  logic [NCHAN-1:0] pend_d, elig, din_n, w1c, edge_set, ack_clr;
  logic [2:0]       act, act_d, win;
  logic             spur, spur_d;
  logic             vf, ack_done, found;
  logic [15:0]      intvec_d, vec_win;
  logic             unused_ok;

  assign unused_ok = ^{ADDR[0], DIN};

  assign din_n    = DIN[NCHAN-1:0];
  assign elig     = pend & mask;
  assign vf       = BS & ~BA & (ADDR[15:1] == 15'h7FFC);
  assign w1c      = (WE && REG_SEL == 2'd2) ? din_n : '0;
  assign edge_set = REQ & ~req_q;
  assign vec_win  = VEC_BASE + {12'h000, win, 1'b0};

  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      if (elig[i] && !found) begin
        win   = 3'(i);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state;
    act_d    = act;
    spur_d   = spur;
    intvec_d = Intvector;
    ack_done = 1'b0;
    case (state)
      IDLE: begin
        if (vf) begin
          act_d   = win;
          spur_d  = (elig == '0);
          state_d = ACK;
        end else begin
          intvec_d = (elig != '0) ? vec_win : DEFAULT_VEC;
        end
      end
      ACK: begin
        if (!vf) begin
          ack_done = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Level channels simply follow REQ; edge channels set on a rising REQ and
  // clear on W1C or ack completion, with a simultaneous set taking priority.
  always_comb begin
    ack_clr = '0;
    pend_d  = '0;
    for (int unsigned i = 0; i < NCHAN; i++) begin
      ack_clr[i] = ack_done & ~spur & (3'(i) == act);
      if (mode[i])
        pend_d[i] = edge_set[i] | (pend[i] & ~(w1c[i] | ack_clr[i]));
      else
        pend_d[i] = REQ[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      mask      <= '0;
      mode      <= '0;
      pend      <= '0;
      req_q     <= '0;
      act       <= '0;
      spur      <= 1'b0;
      nIRQ      <= 1'b1;
      Intvector <= DEFAULT_VEC;
    end else begin
      state     <= state_d;
      req_q     <= REQ;
      pend      <= pend_d;
      act       <= act_d;
      spur      <= spur_d;
      nIRQ      <= ~|elig;
      Intvector <= intvec_d;
      if (WE && REG_SEL == 2'd0) mask <= din_n;
      if (WE && REG_SEL == 2'd1) mode <= din_n;
    end
  end

  always_comb begin
    DOUT = '0;
    case (REG_SEL)
      2'd0: DOUT = 8'(mask);
      2'd1: DOUT = 8'(mode);
      2'd2: DOUT = 8'(pend);
      2'd3: DOUT = {(state == ACK), 4'b0000, act};
      default: DOUT = '0;
    endcase
  end

endmodule

// File: tb/tb_mc6809_intvec_ctrl.sv
// Directed self-checking bench for mc6809_intvec_ctrl (NCHAN=8, default vectors).
module tb_mc6809_intvec_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  req;
  logic [15:0] addr;
  logic        bs, ba, we;
  logic [1:0]  reg_sel;
  logic [7:0]  din, dout;
  logic        nirq;
  logic [15:0] intvector;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mc6809_intvec_ctrl #(
    .NCHAN(8),
    .VEC_BASE(16'hFF00),
    .DEFAULT_VEC(16'hFFF8)
  ) dut (
    .CLK(clk),
    .RESET(reset),
    .REQ(req),
    .ADDR(addr),
    .BS(bs),
    .BA(ba),
    .WE(we),
    .REG_SEL(reg_sel),
    .DIN(din),
    .DOUT(dout),
    .nIRQ(nirq),
    .Intvector(intvector)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [7:0] data);
    we = 1'b1; reg_sel = sel; din = data;
    tick();
    we = 1'b0; din = 8'h00;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] sel, input logic [7:0] exp);
    reg_sel = sel;
    #1;
    check(tag, {8'h00, dout}, {8'h00, exp});
  endtask

  task automatic vf_on(input logic [15:0] a);
    bs = 1'b1; ba = 1'b0; addr = a;
  endtask

  task automatic vf_off();
    bs = 1'b0; ba = 1'b0; addr = 16'h0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; req = '0; addr = '0; bs = 1'b0; ba = 1'b0;
    we = 1'b0; reg_sel = '0; din = '0;
    tick(); tick();
    reset = 1'b0;

    // reset state
    check("rst_nirq", {15'h0, nirq}, 16'h0001);
    check("rst_vec", intvector, 16'hFFF8);
    for (int i = 0; i < 4; i++) check_reg("rst_dout", 2'(i), 8'h00);

    // edge capture on channel 0
    wr(2'd0, 8'h01);
    wr(2'd1, 8'h01);
    req = 8'h01; tick(); req = 8'h00;
    check("edge_nirq_1cyc", {15'h0, nirq}, 16'h0001);
    tick();
    check("edge_nirq_2cyc", {15'h0, nirq}, 16'h0000);
    check("edge_vec", intvector, 16'hFF00);
    check_reg("edge_pend", 2'd2, 8'h01);
    vf_on(16'hFFF8); tick();
    check_reg("edge_status", 2'd3, 8'h80);
    vf_on(16'hFFF9); tick();
    vf_off(); tick();
    check_reg("edge_pend_clr", 2'd2, 8'h00);
    check("edge_nirq_hold", {15'h0, nirq}, 16'h0000);
    tick();
    check("edge_nirq_rel", {15'h0, nirq}, 16'h0001);
    check("edge_vec_idle", intvector, 16'hFFF8);

    // priority: channels 5 and 2 together
    wr(2'd0, 8'hFF);
    wr(2'd1, 8'hFF);
    req = 8'h24; tick(); req = 8'h00;
    tick();
    check("prio_vec", intvector, 16'hFF04);
    check_reg("prio_pend", 2'd2, 8'h24);
    vf_on(16'hFFF8); tick();
    vf_off(); tick();
    tick();
    check("prio_vec_next", intvector, 16'hFF0A);
    check_reg("prio_pend_after", 2'd2, 8'h20);
    wr(2'd2, 8'h20);
    check_reg("w1c_clear", 2'd2, 8'h00);
    tick();
    check("w1c_nirq", {15'h0, nirq}, 16'h0001);

    // freeze during ack of channel 3
    req = 8'h08; tick(); req = 8'h00;
    tick();
    check("frz_vec_pre", intvector, 16'hFF06);
    vf_on(16'hFFF8); tick();
    req = 8'h02; we = 1'b1; reg_sel = 2'd0; din = 8'h00;
    tick();
    req = 8'h00; we = 1'b0;
    check("frz_vec_a", intvector, 16'hFF06);
    check_reg("frz_status", 2'd3, 8'h83);
    tick();
    check("frz_vec_b", intvector, 16'hFF06);
    vf_off(); tick();
    check_reg("frz_pend", 2'd2, 8'h02);
    check("frz_vec_c", intvector, 16'hFF06);
    tick();
    check("frz_vec_idle", intvector, 16'hFFF8);
    check("frz_nirq", {15'h0, nirq}, 16'h0001);
    wr(2'd2, 8'hFF);
    check_reg("frz_pend_clr", 2'd2, 8'h00);

    // level mode on channel 2
    wr(2'd1, 8'h00);
    wr(2'd0, 8'h04);
    req = 8'h04; tick(); tick();
    check("lvl_nirq", {15'h0, nirq}, 16'h0000);
    check("lvl_vec", intvector, 16'hFF04);
    vf_on(16'hFFF8); tick(); tick();
    vf_off(); tick(); tick();
    check_reg("lvl_pend", 2'd2, 8'h04);
    check("lvl_nirq_ack", {15'h0, nirq}, 16'h0000);
    req = 8'h00; tick();
    check("lvl_nirq_1cyc", {15'h0, nirq}, 16'h0000);
    tick();
    check("lvl_nirq_2cyc", {15'h0, nirq}, 16'h0001);
    check("lvl_vec_idle", intvector, 16'hFFF8);

    // spurious fetch
    vf_on(16'hFFF9); tick();
    check("spur_vec", intvector, 16'hFFF8);
    check_reg("spur_status", 2'd3, 8'h80);
    check_reg("spur_pend", 2'd2, 8'h00);
    vf_off(); tick();
    check_reg("spur_pend_after", 2'd2, 8'h00);
    check_reg("spur_status_idle", 2'd3, 8'h00);

    // W1C racing a rising edge: set wins
    wr(2'd1, 8'h10);
    wr(2'd0, 8'h10);
    req = 8'h10; we = 1'b1; reg_sel = 2'd2; din = 8'h10;
    tick();
    we = 1'b0; req = 8'h00;
    check_reg("race_pend", 2'd2, 8'h10);
    tick();
    check_reg("race_pend_hold", 2'd2, 8'h10);
    check("race_nirq", {15'h0, nirq}, 16'h0000);
    wr(2'd2, 8'h10);
    check_reg("race_w1c", 2'd2, 8'h00);

    // reset in the middle of an ack
    tick();
    req = 8'h10; tick(); req = 8'h00;
    tick();
    check("rmid_vec_pre", intvector, 16'hFF08);
    vf_on(16'hFFF8); tick();
    check_reg("rmid_status_ack", 2'd3, 8'h84);
    reset = 1'b1; tick();
    reset = 1'b0; vf_off();
    check("rmid_nirq", {15'h0, nirq}, 16'h0001);
    check("rmid_vec", intvector, 16'hFFF8);
    for (int i = 0; i < 4; i++) check_reg("rmid_dout", 2'(i), 8'h00);
    tick();
    check_reg("rmid_status_idle", 2'd3, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
